// File: rtl/qspi_pkg.sv
// Shared constants for the QSPI write-data sender: FSM encoding, byte lanes, defaults.
package qspi_pkg;

  localparam int LEN_W_DEF      = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  // Byte lanes within a 32-bit write word; lane 0 goes out first.
  localparam logic [1:0] LANE_FIRST = 2'd0;
  localparam logic [1:0] LANE_LAST  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Pick one byte lane out of a write word.
  function automatic logic [BYTE_W-1:0] lane_sel(input logic [WORD_W-1:0] w,
                                                 input logic [1:0] idx);
    return w[{idx, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/qspi_tdata_sender_if.sv
// Command, write-data and shift-engine handshakes of the write-data sender.
interface qspi_tdata_sender_if #(
  parameter int LEN_W = 8
);
  import qspi_pkg::*;

  logic              io_tdata_lock;
  logic              io_cmd_valid;
  logic [LEN_W-1:0]  io_cmd_len;
  logic              io_cmd_ready;
  logic              io_dchan_tdata_valid;
  logic [WORD_W-1:0] io_dchan_tdata;
  logic              io_dchan_tdata_ready;
  logic              io_tx_valid;
  logic [BYTE_W-1:0] io_tx_byte;
  logic              io_tx_ready;
  logic              io_dchan_tdata_key;
  logic              io_busy;
  logic              io_err;

  // The sender itself.
  modport slave (
    input  io_tdata_lock, io_cmd_valid, io_cmd_len, io_dchan_tdata_valid,
           io_dchan_tdata, io_tx_ready,
    output io_cmd_ready, io_dchan_tdata_ready, io_tx_valid, io_tx_byte,
           io_dchan_tdata_key, io_busy, io_err
  );

  // Whoever drives commands/data and consumes bytes.
  modport master (
    output io_tdata_lock, io_cmd_valid, io_cmd_len, io_dchan_tdata_valid,
           io_dchan_tdata, io_tx_ready,
    input  io_cmd_ready, io_dchan_tdata_ready, io_tx_valid, io_tx_byte,
           io_dchan_tdata_key, io_busy, io_err
  );

endinterface

// File: rtl/qspi_tdata_fifo.sv
// Small synchronous FIFO with registered write (no bypass) and a combinational head.
module qspi_tdata_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             push_ok, pop_ok;

  // Extra pointer MSB tells full from empty when the indices coincide.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_q[AW-1:0]];

  // Next pointers and storage contents.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_ok) begin
      mem_d[wr_q[AW-1:0]] = wdata;
      wr_d                = wr_q + (AW+1)'(1);
    end
    if (pop_ok) rd_d = rd_q + (AW+1)'(1);
  end

  // Pointer and storage registers, all cleared on reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/qspi_tdata_sender.sv
// Drains one write burst from the locked data channel and serialises it LSB byte
// first to the shift engine, then pulses the unlock key.
module qspi_tdata_sender
  import qspi_pkg::*;
#(
  parameter int LEN_W      = LEN_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input logic               clock,
  input logic               rst_n,
  qspi_tdata_sender_if.slave io
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [LEN_W-2:0] words_in_q, words_in_d;
  logic [LEN_W-2:0] words_needed_q, words_needed_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic             err_q, err_d;

  logic              fifo_full, fifo_empty;
  logic [WORD_W-1:0] fifo_head;
  logic              cmd_hs, push, tx_hs, pop, last_byte, need_more;
  logic [LEN_W-2:0]  len_words;

  assign cmd_hs    = io.io_cmd_valid && io.io_cmd_ready;
  assign push      = io.io_dchan_tdata_valid && io.io_dchan_tdata_ready;
  assign tx_hs     = io.io_tx_valid && io.io_tx_ready;
  assign last_byte = (remaining_q == LEN_W'(1));
  // The last partial word is popped early; its unused upper lanes are dropped.
  assign pop       = tx_hs && ((byte_idx_q == LANE_LAST) || last_byte);
  assign need_more = (words_in_q < words_needed_q);
  // ceil(len/4) without needing a wider adder.
  assign len_words = {1'b0, io.io_cmd_len[LEN_W-1:2]}
                   + {{(LEN_W-2){1'b0}}, |io.io_cmd_len[1:0]};

  qspi_tdata_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .rst_n (rst_n),
    .push  (push),
    .wdata (io.io_dchan_tdata),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // State and counter registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      remaining_q    <= '0;
      words_in_q     <= '0;
      words_needed_q <= '0;
      byte_idx_q     <= LANE_FIRST;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      words_in_q     <= words_in_d;
      words_needed_q <= words_needed_d;
      byte_idx_q     <= byte_idx_d;
      err_q          <= err_d;
    end
  end

  // Next state: a zero-length command goes straight to the key pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_hs) state_d = (io.io_cmd_len == '0) ? DONE : RUN;
      RUN:  if (tx_hs && last_byte) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst counters, lane select and the sticky lost-lock flag.
  always_comb begin
    remaining_d    = remaining_q;
    words_in_d     = words_in_q;
    words_needed_d = words_needed_q;
    byte_idx_d     = byte_idx_q;
    err_d          = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          err_d          = 1'b0;
          remaining_d    = io.io_cmd_len;
          words_needed_d = len_words;
          words_in_d     = '0;
          byte_idx_d     = LANE_FIRST;
        end
      end
      RUN: begin
        if (push) words_in_d = words_in_q + (LEN_W-1)'(1);
        if (tx_hs) begin
          remaining_d = remaining_q - LEN_W'(1);
          byte_idx_d  = pop ? LANE_FIRST : byte_idx_q + 2'd1;
        end
        // Lock gone while the burst is only partly fetched.
        if (!io.io_tdata_lock && (words_in_q != '0) && need_more) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    io.io_cmd_ready         = 1'b0;
    io.io_dchan_tdata_ready = 1'b0;
    io.io_tx_valid          = 1'b0;
    io.io_dchan_tdata_key   = 1'b0;
    io.io_tx_byte           = lane_sel(fifo_head, byte_idx_q);
    io.io_busy              = (state_q != IDLE);
    io.io_err               = err_q;
    case (state_q)
      IDLE: io.io_cmd_ready = 1'b1;
      RUN: begin
        io.io_dchan_tdata_ready = io.io_tdata_lock && !fifo_full && need_more;
        io.io_tx_valid          = !fifo_empty;
      end
      DONE: io.io_dchan_tdata_key = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_qspi_tdata_sender.sv
// Directed bench for qspi_tdata_sender: a per-cycle vector table for a plain
// 4-byte burst plus hand-written multi-cycle sequences.
module tb_qspi_tdata_sender;
  import qspi_pkg::*;

  localparam int LW    = 8;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  qspi_tdata_sender_if #(.LEN_W(LW)) bif ();

  qspi_tdata_sender #(.LEN_W(LW), .FIFO_DEPTH(DEPTH)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .io    (bif)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] words [8];

  typedef struct {
    logic        cv;
    logic [7:0]  len;
    logic        dv;
    logic [31:0] dw;
    logic        tr;
    logic        e_cr;
    logic        e_dr;
    logic        e_tv;
    logic [7:0]  e_tb;
    logic        e_key;
    logic        e_busy;
  } vec_t;

  vec_t tbl [8];

  function automatic vec_t mk(logic cv, logic [7:0] len, logic dv, logic [31:0] dw,
                              logic tr, logic e_cr, logic e_dr, logic e_tv,
                              logic [7:0] e_tb, logic e_key, logic e_busy);
    vec_t v;
    v.cv = cv; v.len = len; v.dv = dv; v.dw = dw; v.tr = tr;
    v.e_cr = e_cr; v.e_dr = e_dr; v.e_tv = e_tv; v.e_tb = e_tb;
    v.e_key = e_key; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " cmd_ready"},   32'(bif.io_cmd_ready), 1);
    chk({tag, " tdata_ready"}, 32'(bif.io_dchan_tdata_ready), 0);
    chk({tag, " tx_valid"},    32'(bif.io_tx_valid), 0);
    chk({tag, " tx_byte"},     32'(bif.io_tx_byte), 0);
    chk({tag, " key"},         32'(bif.io_dchan_tdata_key), 0);
    chk({tag, " busy"},        32'(bif.io_busy), 0);
    chk({tag, " err"},         32'(bif.io_err), 0);
  endtask

  // One burst using words[]: nw words offered, tx_ready held low for txhold
  // cycles, lock dropped once the first word is in until cycle lock_until.
  task automatic run_burst(input string tag, input int len, input int nw,
                           input int txhold, input int lock_until, input logic exp_err);
    int acc = 0;
    int bi = 0;
    int last_tx = -10;
    logic key_seen = 1'b0;
    logic [31:0] ew;
    bif.io_cmd_valid = 1'b1;
    bif.io_cmd_len = LW'(len);
    bif.io_dchan_tdata_valid = 1'b0;
    bif.io_tx_ready = 1'b0;
    bif.io_tdata_lock = 1'b1;
    settle;
    chk({tag, " cmd_ready"}, 32'(bif.io_cmd_ready), 1);
    step;
    bif.io_cmd_valid = 1'b0;
    settle;
    chk({tag, " err after cmd"}, 32'(bif.io_err), 0);
    chk({tag, " busy"}, 32'(bif.io_busy), 1);
    for (int cyc = 0; cyc < 300 && !key_seen; cyc++) begin
      bif.io_dchan_tdata_valid = (acc < nw);
      bif.io_dchan_tdata = words[acc < 8 ? acc : 0];
      bif.io_tx_ready = (cyc >= txhold);
      bif.io_tdata_lock = !(acc >= 1 && cyc < lock_until);
      settle;
      if (!bif.io_tdata_lock) chk({tag, " ready while unlocked"}, 32'(bif.io_dchan_tdata_ready), 0);
      if (bif.io_dchan_tdata_valid && bif.io_dchan_tdata_ready) acc++;
      if (bif.io_dchan_tdata_key) begin
        key_seen = 1'b1;
        chk({tag, " key after last byte"}, 32'(last_tx), 32'(cyc - 1));
        chk({tag, " byte count"}, 32'(bi), 32'(len));
        chk({tag, " ready in DONE"}, 32'(bif.io_dchan_tdata_ready), 0);
        chk({tag, " tx_valid in DONE"}, 32'(bif.io_tx_valid), 0);
      end else if (bif.io_tx_valid) begin
        if (bi >= len) begin
          chk({tag, " extra byte"}, 32'(bi + 1), 32'(len));
        end else begin
          ew = words[bi / 4] >> (8 * (bi % 4));
          chk({tag, " tx_byte"}, 32'(bif.io_tx_byte), 32'(ew[7:0]));
          if (bif.io_tx_ready) begin
            bi++;
            last_tx = cyc;
          end
        end
      end
      if (txhold > 4 && cyc == txhold - 1) begin
        chk({tag, " words while stalled"}, 32'(acc), DEPTH);
        chk({tag, " ready when full"}, 32'(bif.io_dchan_tdata_ready), 0);
      end
      step;
    end
    if (!key_seen) chk({tag, " key timeout"}, 32'(key_seen), 1);
    chk({tag, " words accepted"}, 32'(acc), 32'((len + 3) / 4));
    chk({tag, " err"}, 32'(bif.io_err), 32'(exp_err));
    bif.io_dchan_tdata_valid = 1'b0;
    bif.io_tx_ready = 1'b0;
    settle;
    chk({tag, " cmd_ready back"}, 32'(bif.io_cmd_ready), 1);
    chk({tag, " key one cycle"}, 32'(bif.io_dchan_tdata_key), 0);
    chk({tag, " busy cleared"}, 32'(bif.io_busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    bif.io_tdata_lock = 1'b1;
    bif.io_cmd_valid = 1'b0;
    bif.io_cmd_len = '0;
    bif.io_dchan_tdata_valid = 1'b0;
    bif.io_dchan_tdata = '0;
    bif.io_tx_ready = 1'b0;

    // Reset state.
    step;
    step;
    settle;
    chk_reset_outs("reset");
    rst_n = 1'b1;
    step;

    // len=4, one word, tx_ready high: one row per cycle.
    tbl[0] = mk(1, 4, 1, 32'h44332211, 1, 1, 0, 0, 8'h00, 0, 0);
    tbl[1] = mk(0, 0, 1, 32'h44332211, 1, 0, 1, 0, 8'h00, 0, 1);
    tbl[2] = mk(0, 0, 0, 32'h0,        1, 0, 0, 1, 8'h11, 0, 1);
    tbl[3] = mk(0, 0, 0, 32'h0,        1, 0, 0, 1, 8'h22, 0, 1);
    tbl[4] = mk(0, 0, 0, 32'h0,        1, 0, 0, 1, 8'h33, 0, 1);
    tbl[5] = mk(0, 0, 0, 32'h0,        1, 0, 0, 1, 8'h44, 0, 1);
    tbl[6] = mk(0, 0, 0, 32'h0,        1, 0, 0, 0, 8'h00, 1, 1);
    tbl[7] = mk(0, 0, 0, 32'h0,        0, 1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++) begin
      bif.io_cmd_valid = tbl[i].cv;
      bif.io_cmd_len = tbl[i].len;
      bif.io_dchan_tdata_valid = tbl[i].dv;
      bif.io_dchan_tdata = tbl[i].dw;
      bif.io_tx_ready = tbl[i].tr;
      settle;
      chk($sformatf("vec%0d cmd_ready", i),   32'(bif.io_cmd_ready), 32'(tbl[i].e_cr));
      chk($sformatf("vec%0d tdata_ready", i), 32'(bif.io_dchan_tdata_ready), 32'(tbl[i].e_dr));
      chk($sformatf("vec%0d tx_valid", i),    32'(bif.io_tx_valid), 32'(tbl[i].e_tv));
      if (tbl[i].e_tv) chk($sformatf("vec%0d tx_byte", i), 32'(bif.io_tx_byte), 32'(tbl[i].e_tb));
      chk($sformatf("vec%0d key", i),  32'(bif.io_dchan_tdata_key), 32'(tbl[i].e_key));
      chk($sformatf("vec%0d busy", i), 32'(bif.io_busy), 32'(tbl[i].e_busy));
      chk($sformatf("vec%0d err", i),  32'(bif.io_err), 0);
      step;
    end

    // len=6: partial last word, a third word is offered but must be refused.
    words[0] = 32'hDDCCBBAA;
    words[1] = 32'h00FFEE99;
    words[2] = 32'h12345678;
    run_burst("len6", 6, 3, 0, 0, 1'b0);

    // len=20 with the shift engine stalled: FIFO fills to depth, head stays put.
    words[0] = 32'h44332211;
    words[1] = 32'h88776655;
    words[2] = 32'hCCBBAA99;
    words[3] = 32'h00FFEEDD;
    words[4] = 32'h5A4B3C2D;
    run_burst("len20", 20, 5, 20, 0, 1'b0);

    // len=8 with the lock lost after the first word.
    words[0] = 32'h03020100;
    words[1] = 32'h07060504;
    run_burst("lock", 8, 2, 0, 8, 1'b1);
    settle;
    chk("err sticky in idle", 32'(bif.io_err), 1);

    // len=0: key the cycle after the command, cmd_ready the cycle after that.
    step;
    bif.io_cmd_valid = 1'b1;
    bif.io_cmd_len = '0;
    bif.io_dchan_tdata_valid = 1'b1;
    bif.io_dchan_tdata = 32'hCAFEF00D;
    settle;
    chk("len0 cmd_ready", 32'(bif.io_cmd_ready), 1);
    step;
    bif.io_cmd_valid = 1'b0;
    settle;
    chk("len0 key", 32'(bif.io_dchan_tdata_key), 1);
    chk("len0 cmd_ready low", 32'(bif.io_cmd_ready), 0);
    chk("len0 tdata_ready", 32'(bif.io_dchan_tdata_ready), 0);
    chk("len0 err cleared", 32'(bif.io_err), 0);
    step;
    settle;
    chk("len0 key gone", 32'(bif.io_dchan_tdata_key), 0);
    chk("len0 cmd_ready back", 32'(bif.io_cmd_ready), 1);
    chk("len0 tdata_ready idle", 32'(bif.io_dchan_tdata_ready), 0);
    bif.io_dchan_tdata_valid = 1'b0;
    step;

    // Reset after 2 of 8 bytes.
    words[0] = 32'h44332211;
    words[1] = 32'h88776655;
    bif.io_cmd_valid = 1'b1;
    bif.io_cmd_len = 8'd8;
    settle;
    step;
    bif.io_cmd_valid = 1'b0;
    nb = 0;
    for (int cyc = 0, acc = 0; cyc < 50 && nb < 2; cyc++) begin
      bif.io_dchan_tdata_valid = (acc < 2);
      bif.io_dchan_tdata = words[acc < 2 ? acc : 0];
      bif.io_tx_ready = 1'b1;
      settle;
      if (bif.io_dchan_tdata_valid && bif.io_dchan_tdata_ready) acc++;
      if (bif.io_tx_valid) nb++;
      step;
    end
    chk("rst bytes before reset", 32'(nb), 2);
    chk("rst busy before reset", 32'(bif.io_busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midreset");
    bif.io_dchan_tdata_valid = 1'b0;
    bif.io_tx_ready = 1'b0;
    step;
    chk("midreset no key", 32'(bif.io_dchan_tdata_key), 0);
    rst_n = 1'b1;
    step;

    // A fresh single-byte burst after reset.
    words[0] = 32'h000000A5;
    run_burst("len1", 1, 1, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
